// File: rtl/stream_checker.sv
// stream_checker: sink end of the bench valid/ready datapath.
// Beats enter a 2-entry skid buffer and are drained by a check stage that
// compares each beat against an incrementing expected value. The check stage
// can be throttled to one beat every DELAY+1 cycles. All outputs are registered.
module stream_checker #(
    parameter int DW    = 32,
    parameter int DELAY = 0,
    parameter int START = 0,
    parameter int CW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    output logic          up_ready,
    output logic [CW-1:0] beat_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err_flag,
    output logic [DW-1:0] first_err_data,
    output logic [DW-1:0] first_err_exp
);

    // Delay counter must hold DELAY; keep at least one bit when DELAY is 0.
    localparam int DLW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [DLW-1:0]  dly;
    logic [DW-1:0]   exp_val;

    // slot0 is always the head of the buffer, slot1 the entry behind it.
    logic [DW-1:0]   slot0;
    logic [DW-1:0]   slot1;
    logic [1:0]      occ;
    logic [1:0]      occ_next;

    logic            push;
    logic            pop;
    logic            mismatch;

    // Handshake decode and next occupancy; a push is never popped on the same edge.
    always_comb begin
        push     = up_valid & up_ready;
        pop      = (state == IDLE) && (occ != 2'd0);
        mismatch = (slot0 != exp_val);
        occ_next = occ + {1'b0, push} - {1'b0, pop};
    end

    // Skid buffer storage, occupancy and the registered ready derived from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            up_ready <= 1'b0;
            slot0    <= '0;
            slot1    <= '0;
        end else begin
            occ      <= occ_next;
            up_ready <= (occ_next != 2'd2);
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        slot0 <= up_data;
                    end else begin
                        slot1 <= up_data;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        slot0 <= up_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= up_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Check stage: compare the head beat, update statistics, then pace via WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dly            <= '0;
            exp_val        <= DW'(START);
            beat_cnt       <= '0;
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_err_data <= '0;
            first_err_exp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        exp_val  <= exp_val + DW'(1);
                        if (mismatch) begin
                            if (err_cnt != {CW{1'b1}}) begin
                                err_cnt <= err_cnt + CW'(1);
                            end
                            if (!err_flag) begin
                                err_flag       <= 1'b1;
                                first_err_data <= slot0;
                                first_err_exp  <= exp_val;
                            end
                        end
                        if (DELAY > 0) begin
                            dly   <= DLW'(DELAY);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dly <= DLW'(1)) begin
                        dly   <= '0;
                        state <= IDLE;
                    end else begin
                        dly <= dly - DLW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker: drives two stream_checker instances with different
// parameter sets and compares every output each cycle against a behavioural
// model built from a log of accepted beats and a next-allowed-pop time.
module tb_stream_checker;

   localparam int DW0 = 32;
   localparam int CW0 = 32;
   localparam int DL0 = 0;
   localparam int ST0 = 0;

   localparam int DW1 = 8;
   localparam int CW1 = 4;
   localparam int DL1 = 3;
   localparam int ST1 = 250;

   logic clk = 1'b0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   logic           rst0 = 1'b1;
   logic           valid0 = 1'b0;
   logic [DW0-1:0] data0 = '0;
   logic           ready0;
   logic [CW0-1:0] beat0;
   logic [CW0-1:0] err0;
   logic           flag0;
   logic [DW0-1:0] fd0;
   logic [DW0-1:0] fe0;

   logic           rst1 = 1'b1;
   logic           valid1 = 1'b0;
   logic [DW1-1:0] data1 = '0;
   logic           ready1;
   logic [CW1-1:0] beat1;
   logic [CW1-1:0] err1;
   logic           flag1;
   logic [DW1-1:0] fd1;
   logic [DW1-1:0] fe1;

   stream_checker #(.DW(DW0), .DELAY(DL0), .START(ST0), .CW(CW0)) dut0 (
      .clk(clk), .rst(rst0), .up_valid(valid0), .up_data(data0), .up_ready(ready0),
      .beat_cnt(beat0), .err_cnt(err0), .err_flag(flag0),
      .first_err_data(fd0), .first_err_exp(fe0)
   );

   stream_checker #(.DW(DW1), .DELAY(DL1), .START(ST1), .CW(CW1)) dut1 (
      .clk(clk), .rst(rst1), .up_valid(valid1), .up_data(data1), .up_ready(ready1),
      .beat_cnt(beat1), .err_cnt(err1), .err_flag(flag1),
      .first_err_data(fd1), .first_err_exp(fe1)
   );

   int nChecks = 0;
   int nPass   = 0;

   // Reference model state, one slot per DUT instance.
   logic [63:0] mHist [2][4096];
   int          mWr [2];
   int          mRd [2];
   int          mCycle [2];
   int          mNextPop [2];
   logic        mReady [2];
   logic        mAcc [2];
   logic        mFlag [2];
   logic [63:0] mExp [2];
   logic [63:0] mBeat [2];
   logic [63:0] mErr [2];
   logic [63:0] mFd [2];
   logic [63:0] mFe [2];

   // Automatic drivers: beats waiting to be offered, and the offer rate in percent.
   logic [63:0] sendQ0 [$];
   logic [63:0] sendQ1 [$];
   bit          auto0 = 1'b0;
   bit          auto1 = 1'b0;
   int          rate0 = 100;
   int          rate1 = 100;

   function automatic logic [63:0] dwMask(input int id);
      return (id == 0) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
   endfunction

   function automatic logic [63:0] cwMask(input int id);
      return (id == 0) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_000F;
   endfunction

   function automatic int delayOf(input int id);
      return (id == 0) ? DL0 : DL1;
   endfunction

   function automatic logic [63:0] startOf(input int id);
      return (id == 0) ? 64'(ST0) : 64'(ST1);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual === expected) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic boundExpired(input string name);
      nChecks++;
      $display("[TB] FAIL %s: cycle budget expired", name);
   endtask

   // One rising edge of the model: pop the oldest logged beat if allowed, then log any new beat.
   task automatic modelEdge(input int id, input logic r, input logic v, input logic [63:0] d);
      logic [63:0] head;
      mCycle[id]++;
      if (r) begin
         mWr[id] = 0;
         mRd[id] = 0;
         mReady[id] = 1'b0;
         mAcc[id] = 1'b0;
         mExp[id] = startOf(id);
         mBeat[id] = 0;
         mErr[id] = 0;
         mFlag[id] = 1'b0;
         mFd[id] = 0;
         mFe[id] = 0;
         mNextPop[id] = 0;
      end else begin
         mAcc[id] = v && mReady[id];
         if ((mWr[id] != mRd[id]) && (mCycle[id] >= mNextPop[id])) begin
            head = mHist[id][mRd[id] % 4096];
            mRd[id]++;
            if (head != mExp[id]) begin
               if (mErr[id] != cwMask(id)) mErr[id] = mErr[id] + 1;
               if (!mFlag[id]) begin
                  mFlag[id] = 1'b1;
                  mFd[id] = head;
                  mFe[id] = mExp[id];
               end
            end
            mBeat[id] = (mBeat[id] + 1) & cwMask(id);
            mExp[id] = (mExp[id] + 1) & dwMask(id);
            mNextPop[id] = mCycle[id] + delayOf(id) + 1;
         end
         if (mAcc[id]) begin
            mHist[id][mWr[id] % 4096] = d & dwMask(id);
            mWr[id]++;
         end
         mReady[id] = (mWr[id] - mRd[id]) < 2;
      end
   endtask

   task automatic compareModel();
      checkOutput("d0.up_ready", 64'(ready0), 64'(mReady[0]));
      checkOutput("d0.beat_cnt", 64'(beat0), mBeat[0]);
      checkOutput("d0.err_cnt", 64'(err0), mErr[0]);
      checkOutput("d0.err_flag", 64'(flag0), 64'(mFlag[0]));
      checkOutput("d0.first_err_data", 64'(fd0), mFd[0]);
      checkOutput("d0.first_err_exp", 64'(fe0), mFe[0]);
      checkOutput("d1.up_ready", 64'(ready1), 64'(mReady[1]));
      checkOutput("d1.beat_cnt", 64'(beat1), mBeat[1]);
      checkOutput("d1.err_cnt", 64'(err1), mErr[1]);
      checkOutput("d1.err_flag", 64'(flag1), 64'(mFlag[1]));
      checkOutput("d1.first_err_data", 64'(fd1), mFd[1]);
      checkOutput("d1.first_err_exp", 64'(fe1), mFe[1]);
   endtask

   // Advance one cycle: model the edge, compare at the falling edge, then drive the next offer.
   task automatic tick();
      @(posedge clk);
      modelEdge(0, rst0, valid0, 64'(data0));
      modelEdge(1, rst1, valid1, 64'(data1));
      @(negedge clk);
      if (auto0 && mAcc[0]) void'(sendQ0.pop_front());
      if (auto1 && mAcc[1]) void'(sendQ1.pop_front());
      compareModel();
      if (auto0) begin
         if (sendQ0.size() > 0 && $urandom_range(0, 99) < rate0) begin
            valid0 = 1'b1;
            data0 = DW0'(sendQ0[0]);
         end else begin
            valid0 = 1'b0;
            data0 = DW0'($urandom);
         end
      end
      if (auto1) begin
         if (sendQ1.size() > 0 && $urandom_range(0, 99) < rate1) begin
            valid1 = 1'b1;
            data1 = DW1'(sendQ1[0]);
         end else begin
            valid1 = 1'b0;
            data1 = DW1'($urandom);
         end
      end
   endtask

   task automatic resetDut(input int id);
      if (id == 0) begin
         rst0 = 1'b1; valid0 = 1'b0; auto0 = 1'b0; sendQ0.delete();
      end else begin
         rst1 = 1'b1; valid1 = 1'b0; auto1 = 1'b0; sendQ1.delete();
      end
      tick();
      if (id == 0) rst0 = 1'b0;
      else rst1 = 1'b0;
      tick();
   endtask

   task automatic waitDrain(input int budget, input string name);
      int n = 0;
      while ((sendQ0.size() > 0 || sendQ1.size() > 0 || mWr[0] != mRd[0] || mWr[1] != mRd[1])
             && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) boundExpired(name);
   endtask

   typedef struct {
      logic        valid;
      logic [31:0] data;
      logic        ready;
      int          beat;
      int          err;
      logic        flag;
   } vec_t;

   // Apply the directed mismatch table to dut0, one row per cycle.
   task automatic applyStimulus();
      vec_t vecs [8];
      vecs[0] = '{1'b1, 32'd0, 1'b1, 0, 0, 1'b0};
      vecs[1] = '{1'b1, 32'd1, 1'b1, 1, 0, 1'b0};
      vecs[2] = '{1'b1, 32'd2, 1'b1, 2, 0, 1'b0};
      vecs[3] = '{1'b1, 32'd7, 1'b1, 3, 0, 1'b0};
      vecs[4] = '{1'b1, 32'd4, 1'b1, 4, 1, 1'b1};
      vecs[5] = '{1'b1, 32'd9, 1'b1, 5, 1, 1'b1};
      vecs[6] = '{1'b0, 32'd0, 1'b1, 6, 2, 1'b1};
      vecs[7] = '{1'b0, 32'd0, 1'b1, 6, 2, 1'b1};
      for (int i = 0; i < 8; i++) begin
         valid0 = vecs[i].valid;
         data0 = vecs[i].data;
         tick();
         checkOutput($sformatf("tbl%0d.up_ready", i), 64'(ready0), 64'(vecs[i].ready));
         checkOutput($sformatf("tbl%0d.beat_cnt", i), 64'(beat0), 64'(vecs[i].beat));
         checkOutput($sformatf("tbl%0d.err_cnt", i), 64'(err0), 64'(vecs[i].err));
         checkOutput($sformatf("tbl%0d.err_flag", i), 64'(flag0), 64'(vecs[i].flag));
      end
      checkOutput("tbl.first_err_data", 64'(fd0), 64'd7);
      checkOutput("tbl.first_err_exp", 64'(fe0), 64'd3);
   endtask

   initial begin
      int drops;
      int cyc;
      int accT [$];
      bit accNow;

      for (int i = 0; i < 2; i++) begin
         mWr[i] = 0; mRd[i] = 0; mCycle[i] = 0; mNextPop[i] = 0;
         mReady[i] = 1'b0; mAcc[i] = 1'b0; mFlag[i] = 1'b0;
         mExp[i] = 0; mBeat[i] = 0; mErr[i] = 0; mFd[i] = 0; mFe[i] = 0;
      end

      // Reset state of both instances.
      @(negedge clk);
      tick();
      tick();
      checkOutput("rst.d0.up_ready", 64'(ready0), 64'd0);
      checkOutput("rst.d0.beat_cnt", 64'(beat0), 64'd0);
      checkOutput("rst.d1.up_ready", 64'(ready1), 64'd0);
      checkOutput("rst.d1.err_cnt", 64'(err1), 64'd0);
      rst0 = 1'b0;
      rst1 = 1'b0;
      tick();
      checkOutput("rel.d0.up_ready", 64'(ready0), 64'd1);
      checkOutput("rel.d1.up_ready", 64'(ready1), 64'd1);

      // Directed sequence 0,1,2,7,4,9.
      applyStimulus();

      // 100 back-to-back beats with ready held high.
      resetDut(0);
      drops = 0;
      for (int i = 0; i < 100; i++) begin
         valid0 = 1'b1;
         data0 = DW0'(i);
         tick();
         if (ready0 !== 1'b1) drops++;
      end
      valid0 = 1'b0;
      waitDrain(20, "b2b_drain");
      checkOutput("b2b.ready_drops", 64'(drops), 64'd0);
      checkOutput("b2b.beat_cnt", 64'(beat0), 64'd100);
      checkOutput("b2b.err_cnt", 64'(err0), 64'd0);
      checkOutput("b2b.err_flag", 64'(flag0), 64'd0);

      // Throttled stream through the wrap point: 250..255, 0..3.
      resetDut(1);
      for (int i = 0; i < 10; i++) sendQ1.push_back(64'((ST1 + i) % 256));
      rate1 = 100;
      auto1 = 1'b1;
      cyc = 0;
      while ((sendQ1.size() > 0 || mWr[1] != mRd[1]) && cyc < 200) begin
         accNow = valid1 && ready1;
         tick();
         if (accNow) accT.push_back(cyc);
         cyc++;
      end
      if (cyc >= 200) boundExpired("wrap_drain");
      checkOutput("wrap.accept_count", 64'(accT.size()), 64'd10);
      for (int k = 3; k < accT.size(); k++)
         checkOutput($sformatf("wrap.spacing%0d", k), 64'(accT[k] - accT[k-1]), 64'(DL1 + 1));
      checkOutput("wrap.beat_cnt", 64'(beat1), 64'd10);
      checkOutput("wrap.err_cnt", 64'(err1), 64'd0);
      checkOutput("wrap.err_flag", 64'(flag1), 64'd0);

      // Every beat wrong: error count saturates, beat count wraps.
      resetDut(1);
      for (int i = 0; i < 20; i++) sendQ1.push_back(64'((ST1 + i + 1) % 256));
      auto1 = 1'b1;
      waitDrain(300, "sat_drain");
      checkOutput("sat.err_cnt", 64'(err1), 64'd15);
      checkOutput("sat.beat_cnt", 64'(beat1), 64'd4);
      checkOutput("sat.err_flag", 64'(flag1), 64'd1);
      checkOutput("sat.first_err_data", 64'(fd1), 64'd251);
      checkOutput("sat.first_err_exp", 64'(fe1), 64'd250);

      // Reset with two beats buffered (and one error already recorded).
      resetDut(1);
      sendQ1.push_back(64'd7);
      sendQ1.push_back(64'd251);
      sendQ1.push_back(64'd252);
      sendQ1.push_back(64'd253);
      auto1 = 1'b1;
      cyc = 0;
      while (ready1 !== 1'b0 && cyc < 20) begin
         tick();
         cyc++;
      end
      if (cyc >= 20) boundExpired("midrst_fill");
      checkOutput("midrst.pre_err_cnt", 64'(err1), 64'd1);
      rst1 = 1'b1;
      auto1 = 1'b0;
      valid1 = 1'b0;
      sendQ1.delete();
      tick();
      checkOutput("midrst.up_ready", 64'(ready1), 64'd0);
      checkOutput("midrst.beat_cnt", 64'(beat1), 64'd0);
      checkOutput("midrst.err_cnt", 64'(err1), 64'd0);
      checkOutput("midrst.err_flag", 64'(flag1), 64'd0);
      checkOutput("midrst.first_err_data", 64'(fd1), 64'd0);
      checkOutput("midrst.first_err_exp", 64'(fe1), 64'd0);
      rst1 = 1'b0;
      tick();
      checkOutput("midrst.ready_after", 64'(ready1), 64'd1);
      sendQ1.push_back(64'(ST1));
      auto1 = 1'b1;
      waitDrain(20, "midrst_drain");
      checkOutput("midrst.next_beat_cnt", 64'(beat1), 64'd1);
      checkOutput("midrst.next_err_cnt", 64'(err1), 64'd0);

      // Randomised traffic with occasional corrupted beats on both instances.
      resetDut(0);
      resetDut(1);
      for (int i = 0; i < 600; i++)
         sendQ0.push_back(($urandom_range(0, 9) == 0) ? 64'($urandom) : 64'(ST0 + i));
      for (int i = 0; i < 300; i++)
         sendQ1.push_back(($urandom_range(0, 9) == 0) ? 64'($urandom_range(0, 255)) : 64'((ST1 + i) % 256));
      rate0 = 70;
      rate1 = 85;
      auto0 = 1'b1;
      auto1 = 1'b1;
      waitDrain(4000, "rand_drain");
      checkOutput("rand.d0.beat_cnt", 64'(beat0), 64'd600);
      checkOutput("rand.d1.beat_cnt", 64'(beat1), 64'(300 % 16));

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/stream_checker.md
Name: stream_checker

Overview:
- Sink end of the valid/ready stream driven by `generator`.
- Accepts beats through an internal 2-entry skid buffer, so `up_ready` is a registered output.
- Consumes buffered beats at a rate set by `DELAY`.
- Compares each consumed beat against an expected incrementing sequence; reports beat count, error count, sticky error and the first mismatch.
- Sits at the far end of the bench datapath, opposite the generator.

Parameters:
- DW, 32, data width of `up_data` and of the expected-value counter.
- DELAY, 0, idle cycles the check stage waits after each consumed beat before it may consume the next; 0 = one beat per cycle.
- START, 0, first expected data value after reset.
- CW, 32, width of the beat and error counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- up_valid  input  1  upstream beat valid.
- up_data  input  DW  upstream beat data.
- up_ready  output  1  registered; high when the skid buffer can accept a beat.
- beat_cnt  output  CW  number of beats consumed and checked.
- err_cnt  output  CW  number of mismatching beats, saturating at all-ones.
- err_flag  output  1  sticky; set on first mismatch.
- first_err_data  output  DW  received value of the first mismatching beat.
- first_err_exp  output  DW  expected value at the first mismatch.

Behaviour:
- **Reset**, sampled synchronously on `clk` while `rst` = 1:
  - `up_ready`, buffer occupancy, `beat_cnt`, `err_cnt`, `err_flag`, `first_err_*` = 0; delay counter = 0.
  - exp = START.
  - Reset mid-stream discards buffered beats, with no count or check.
- **Skid buffer:**
  - Upstream transfer occurs when `up_valid` & `up_ready` at a rising edge.
  - `up_ready` is registered: 1 the cycle after `rst` deasserts; thereafter 1 iff occupancy after the current edge is < 2.
  - When occupancy = 1 and `up_ready` = 1, a beat may be pushed and popped on the same edge.
  - Ordering is strict FIFO.
  - No beat is ever lost or duplicated.
  - `up_data` is ignored when `up_valid` = 0.
- **Check stage FSM**, 2 states:
  - IDLE: pop when occupancy > 0. On pop:
    - compare head data vs exp;
    - `beat_cnt` += 1 (wraps at 2^CW);
    - exp += 1 (mod 2^DW, wraps all-ones to 0);
    - if DELAY > 0, load delay counter = DELAY and go to WAIT.
  - WAIT: decrement delay counter each cycle; when it reaches 0, return to IDLE. No pop while in WAIT.
  - The first pop is at the earliest 1 cycle after the push edge, so accept-to-check latency = 1 cycle.
- **Mismatch handling:**
  - exp still advances; there is no resync.
  - `err_cnt` += 1, saturating at 2^CW−1.
  - On the first mismatch only: `err_flag` <= 1, and `first_err_data` / `first_err_exp` are captured.
  - All three hold until reset.
- **Outputs** update on the edge of the pop; all outputs are registered.
- **Throughput:**
  - DELAY=0: sustained 1 beat/cycle with `up_ready` constantly high.
  - DELAY=N: 1 beat per N+1 cycles; `up_ready` drops once the buffer holds 2 beats.

Test Plan:
- DELAY=0, upstream sends 0..99 back-to-back with `up_valid` constantly high → `up_ready` stays 1 after reset, `beat_cnt`=100, `err_cnt`=0, `err_flag`=0.
- DELAY=3, upstream sends 0..19 continuously → accepted beats spaced 4 cycles apart in steady state, `up_ready` toggles, `beat_cnt`=20, no errors, no beat lost.
- Sequence 0,1,2,7,4,9 → `err_cnt`=2, `err_flag`=1, `first_err_data`=7, `first_err_exp`=3, `beat_cnt`=6.
- DW=8, START=250, send 250..255,0..3 → wrap accepted, `err_cnt`=0, `beat_cnt`=10.
- CW=4, all beats wrong, 20 beats → `err_cnt` saturates at 15, `beat_cnt` wraps to 4.
- Assert `rst` for 1 cycle with 2 beats buffered → `up_ready`=0 during reset, 1 the next cycle; counters and `first_err_*` = 0; the next beat is checked against START.
